rfifo_stream_out: RTL and testbench

RFIFO_STREAM_OUT -- requirements
Module: rfifo_stream_out

---
 rtl/rfifo_stream_out.sv | 104 ++++++++++
 tb/tb_rfifo_stream_out.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rfifo_stream_out.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : rfifo_stream_out                                          |
// | Adapts a registered-read async-FIFO read port to a valid/ready     |
// | stream via a 3-entry output buffer. Optional RFIFO_STREAM_STATS_EN |
// | adds pop_cnt / stall_cnt statistics outputs.                       |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module rfifo_stream_out #(
  parameter int DSIZE    = 8,
  parameter int ADDRSIZE = 4
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rempty,
  input  logic                arempty,
  input  logic [DSIZE-1:0]    rdata,
  output logic                rinc,
  output logic                m_valid,
  input  logic                m_ready,
  output logic [DSIZE-1:0]    m_data,
  output logic                m_low
`ifdef RFIFO_STREAM_STATS_EN
  ,
  output logic [ADDRSIZE+11:0] pop_cnt,
  output logic [ADDRSIZE+11:0] stall_cnt
`endif
);

  if (ADDRSIZE < 1 || DSIZE < 1) begin : g_param_chk
    $error("rfifo_stream_out: DSIZE and ADDRSIZE must be positive");
  end

  logic [1:0]       r_occ;
  logic [1:0]       r_head;
  logic [1:0]       r_tail;
  logic             r_inflight;
  logic             r_run;
  logic [DSIZE-1:0] r_buf [3];
  logic             w_wr;
  logic             w_pop;
  logic [2:0]       w_fill;

  function automatic logic [1:0] inc3(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for every word already requested so the buffer can never overflow.
  assign w_fill  = {1'b0, r_occ} + {2'b00, r_inflight};
  assign rinc    = r_run & ~rempty & (w_fill < 3'd3);
  assign w_wr    = r_inflight;
  assign w_pop   = m_valid & m_ready;
  assign m_valid = (r_occ != 2'd0);
  assign m_data  = r_buf[r_head];

  // r_run holds rinc low until the first edge after reset release.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_run      <= 1'b0;
      r_inflight <= 1'b0;
      r_occ      <= 2'd0;
      r_head     <= 2'd0;
      r_tail     <= 2'd0;
      m_low      <= 1'b1;
      r_buf      <= '{default: '0};
    end else begin
      r_run      <= 1'b1;
      r_inflight <= rinc;
      m_low      <= arempty | rempty;
      if (w_wr) begin
        r_buf[r_tail] <= rdata;
        r_tail        <= inc3(r_tail);
      end
      if (w_pop) begin
        r_head <= inc3(r_head);
      end
      case ({w_wr, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

`ifdef RFIFO_STREAM_STATS_EN
  localparam int c_CNT_W = ADDRSIZE + 12;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      pop_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      if (w_pop) begin
        pop_cnt <= pop_cnt + c_CNT_W'(1);
      end
      if (m_ready && !m_valid) begin
        stall_cnt <= stall_cnt + c_CNT_W'(1);
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rfifo_stream_out.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_rfifo_stream_out                                       |
// | Directed + randomized bench for rfifo_stream_out against a queue   |
// | model of the upstream FIFO, output buffer and statistics.          |
// | Rev    : 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_rfifo_stream_out;
  localparam int DSIZE    = 8;
  localparam int ADDRSIZE = 4;

  logic             rclk    = 1'b0;
  logic             rrst_n  = 1'b0;
  logic             rempty  = 1'b1;
  logic             arempty = 1'b0;
  logic             m_ready = 1'b0;
  logic [DSIZE-1:0] rdata   = '0;
  logic             rinc;
  logic             m_valid;
  logic             m_low;
  logic [DSIZE-1:0] m_data;
`ifdef RFIFO_STREAM_STATS_EN
  logic [ADDRSIZE+11:0] pop_cnt;
  logic [ADDRSIZE+11:0] stall_cnt;
`endif

  rfifo_stream_out #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE)) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rempty   (rempty),
    .arempty  (arempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_low    (m_low)
`ifdef RFIFO_STREAM_STATS_EN
    ,
    .pop_cnt  (pop_cnt),
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 rclk = ~rclk;

  int checks = 0;
  int errors = 0;

  logic [DSIZE-1:0] src_q[$];
  logic [DSIZE-1:0] buf_q[$];
  logic [DSIZE-1:0] out_q[$];
  logic [DSIZE-1:0] in_q[$];
  bit               inf_v      = 1'b0;
  logic [DSIZE-1:0] inf_w      = '0;
  bit               started    = 1'b0;
  bit               low_m      = 1'b1;
  bit               hold_empty = 1'b0;
  int               pop_m      = 0;
  int               stall_m    = 0;
  logic             obs_rinc, obs_valid, obs_low;
  logic [DSIZE-1:0] obs_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_flags();
    rempty  = hold_empty || (src_q.size() == 0);
    arempty = (src_q.size() == 1);
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge,
  // then let the upstream FIFO answer the sampled rinc with registered read data.
  task automatic step();
    bit exp_rinc;
    bit exp_valid;
    @(negedge rclk);
    exp_valid = (buf_q.size() != 0);
    exp_rinc  = started && !rempty && ((buf_q.size() + int'(inf_v)) < 3);
    obs_rinc  = rinc;
    obs_valid = m_valid;
    obs_data  = m_data;
    obs_low   = m_low;
    chk("rinc", rinc, exp_rinc);
    chk("m_valid", m_valid, exp_valid);
    if (exp_valid) chk("m_data", m_data, buf_q[0]);
    chk("m_low", m_low, low_m);
`ifdef RFIFO_STREAM_STATS_EN
    chk("pop_cnt", pop_cnt, pop_m);
    chk("stall_cnt", stall_cnt, stall_m);
`endif
    if (m_valid && m_ready) out_q.push_back(m_data);
    @(posedge rclk);
    if (exp_valid && m_ready) begin
      void'(buf_q.pop_front());
      pop_m++;
    end else if (m_ready) begin
      stall_m++;
    end
    if (inf_v) buf_q.push_back(inf_w);
    inf_v   = exp_rinc;
    inf_w   = (exp_rinc && src_q.size() > 0) ? src_q[0] : '0;
    low_m   = rempty | arempty;
    started = 1'b1;
    #1;
    if (obs_rinc && src_q.size() > 0) rdata = src_q.pop_front();
    else rdata = DSIZE'($urandom);
    drive_flags();
  endtask

  // Called at the post-edge phase; holds reset low for one cycle.
  task automatic do_reset();
    rrst_n = 1'b0;
    src_q.delete();
    buf_q.delete();
    inf_v = 1'b0; started = 1'b0; low_m = 1'b1;
    pop_m = 0; stall_m = 0;
    hold_empty = 1'b0; m_ready = 1'b0; rdata = '0;
    rempty = 1'b0; arempty = 1'b0;
    @(negedge rclk);
    chk("rst_rinc", rinc, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_low", m_low, 1);
`ifdef RFIFO_STREAM_STATS_EN
    chk("rst_pop_cnt", pop_cnt, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    @(posedge rclk);
    #1;
    rrst_n = 1'b1;
    drive_flags();
  endtask

  task automatic drain();
    bit done = 1'b0;
    m_ready = 1'b1;
    hold_empty = 1'b0;
    drive_flags();
    for (int k = 0; k < 100 && !done; k++) begin
      step();
      done = (src_q.size() == 0) && (buf_q.size() == 0) && !inf_v;
    end
    chk("drain_done", done, 1);
  endtask

  task automatic load(input int n);
    for (int i = 0; i < n; i++) src_q.push_back(DSIZE'($urandom));
    drive_flags();
  endtask

  initial begin
    int               n;
    bit               ok;
    logic [DSIZE-1:0] first;

    do_reset();

    // Latency and back-to-back data after reset.
    step();
    m_ready = 1'b1;
    src_q = '{8'h11, 8'h22, 8'h33};
    drive_flags();
    step(); chk("t1_rinc_N", obs_rinc, 1);
    step(); chk("t1_valid_N1", obs_valid, 0);
    step(); chk("t1_valid_N2", obs_valid, 1); chk("t1_data0", obs_data, 8'h11);
    step(); chk("t1_data1", obs_data, 8'h22);
    step(); chk("t1_data2", obs_data, 8'h33);
    step(); chk("t1_drained", obs_valid, 0);

    // Downstream stalled: buffer fills to three and the head holds.
    m_ready = 1'b0;
    load(12);
    first = src_q[0];
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (obs_rinc) n++;
    end
    chk("t2_rinc_pulses", n, 3);
    chk("t2_hold_valid", obs_valid, 1);
    chk("t2_hold_data", obs_data, first);
    drain();

    // 20-word stream, ready toggling 1010, random upstream empty gaps.
    out_q.delete();
    load(20);
    in_q = src_q;
    for (int k = 0; k < 400 && out_q.size() < 20; k++) begin
      m_ready    = (k % 2 == 0);
      hold_empty = ($urandom_range(0, 3) == 0);
      drive_flags();
      step();
    end
    chk("t3_count", out_q.size(), 20);
    for (int i = 0; i < 20; i++) begin
      if (i < out_q.size()) chk("t3_word", out_q[i], in_q[i]);
    end
    drain();

    // Reset with two words buffered and one in flight.
    m_ready = 1'b0;
    load(6);
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      step();
      ok = (buf_q.size() == 2) && inf_v;
    end
    chk("t4_reached", ok, 1);
    do_reset();
    step();
    chk("t4_valid_after_rst", obs_valid, 0);
    load(3);
    first = src_q[0];
    out_q.delete();
    drain();
    chk("t4_count", out_q.size(), 3);
    if (out_q.size() > 0) chk("t4_first_new", out_q[0], first);

    // m_low follows arempty|rempty one cycle later.
    m_ready = 1'b0;
    load(4);
    step();
    step(); chk("t5_low_clear", obs_low, 0);
    for (int k = 0; k < 10 && src_q.size() != 1; k++) step();
    step(); chk("t5_low_lag", obs_low, 0);
    step(); chk("t5_low_arempty", obs_low, 1);
    drain();

    // Statistics: 4 starved ready cycles then 5 accepted words.
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    m_ready = 1'b0;
    load(5);
    for (int i = 0; i < 3; i++) step();
    m_ready = 1'b1;
    for (int k = 0; k < 20 && pop_m < 5; k++) step();
    m_ready = 1'b0;
    step();
    chk("t6_pops_model", pop_m, 5);
`ifdef RFIFO_STREAM_STATS_EN
    chk("t6_pop_cnt", pop_cnt, 5);
    chk("t6_stall_cnt", stall_cnt, 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
